sdf_stage_ctrl: RTL and testbench
=================================

Name: sdf_stage_ctrl

Overview:
- Parametrised control unit for one radix-2 single-path delay-feedback (SDF) butterfly stage of the FFT pipeline.
- Replaces the per-stage hard-coded controllers with one block; the delay depth D = 2^LOG_D selects which stage it controls.
- Sequences the fill and butterfly phases, drives shift-register enable, butterfly mux select and twiddle index, and registers the input sample for butterfly port A.
- Adds a ready/valid input handshake, mid-frame stall and end-of-burst flush.

Parameters:
- DW, 17, signed data width of each real/imag component.
- N_LOG, 5, log2 of FFT size N (frame length 2^N_LOG samples).
- LOG_D, 0, log2 of stage delay D; legal range 0..N_LOG-1 (0 is the last stage).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  input sample present.
- ready_o  out  1  block can accept a sample; transfer occurs when valid_i && ready_o.
- data_in_r  in  DW  signed real input.
- data_in_i  in  DW  signed imag input.
- data_out_r  out  DW  registered real sample, to butterfly port A.
- data_out_i  out  DW  registered imag sample, to butterfly port A.
- state  out  2  phase aligned with data_out: 00 IDLE, 01 FILL (bypass), 10 BFLY, 11 FLUSH.
- sr_en  out  1  shift register advances this cycle.
- tw_idx  out  N_LOG-1  twiddle ROM index for the sample in data_out.
- valid_o  out  1  stage output valid this cycle.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, all counters 0, data_out_r/i=0, sr_en=0, tw_idx=0, valid_o=0, ready_o=1. Reset mid-operation abandons the frame; state is IDLE on the next cycle and the first sample of the next frame is sample 0.
- Sample counter idx: N_LOG bits, counts accepted samples modulo N and wraps to 0 at the frame boundary.
- Phase of a sample: bit LOG_D of idx (0 = FILL, 1 = BFLY).
- Latency: a sample accepted at edge t appears on data_out at t+1. state, sr_en and tw_idx are registered with it and describe that sample.
- data_out holds its value on cycles where no sample is accepted.
- IDLE:
  - ready_o=1, valid_o=0, sr_en=0.
  - An accepted sample moves to FILL with idx=0.
- FILL / BFLY:
  - Each accepted sample: sr_en=1, idx increments, state follows the phase bit.
  - valid_o=1 in every BFLY cycle (butterfly sum).
  - valid_o=1 in FILL cycles only when an earlier block of the burst has completed (difference term emitted from the shift register). The first D FILL cycles of a burst have valid_o=0.
- Stall: valid_i low while idx != 0 in FILL/BFLY.
  - sr_en=0, valid_o=0; idx, state and tw_idx hold.
  - Resumes on the next accepted sample.
- End of burst: valid_i low while idx == 0 after at least one full block.
  - Enter FLUSH for exactly D cycles: ready_o=0, sr_en=1, valid_o=1, tw_idx=0.
  - Then IDLE. valid_i is ignored during FLUSH.
- tw_idx:
  - In BFLY = idx[LOG_D-1:0] << (N_LOG-1-LOG_D); otherwise 0.
  - For LOG_D=0, tw_idx is always 0.
- Simultaneous rst and valid_i: rst wins and the sample is dropped.
- After the last FLUSH cycle, a valid_i in IDLE is accepted on that same edge it is sampled.

Test Plan:
- Reset: hold rst for 3 cycles with valid_i=1 -> state=0, valid_o=0, data_out=0, ready_o=1 throughout.
- Last stage, LOG_D=0, N_LOG=5: stream 32 samples 1..32 continuously.
  - state alternates 01,10 starting the cycle after the first accept, so data_out=1 with state=01.
  - valid_o first high with data_out=2.
  - After valid_i drops: one FLUSH cycle with valid_o=1, then IDLE.
- LOG_D=2, N_LOG=5, continuous frame:
  - samples 0-3 FILL with valid_o=0; samples 4-7 BFLY with tw_idx 0,4,8,12; samples 8-11 FILL with valid_o=1.
  - End of burst: 4 FLUSH cycles with ready_o=0.
- Stall, LOG_D=2: drop valid_i for 3 cycles after sample 5 -> sr_en=0, valid_o=0, tw_idx holds at 4, idx unchanged; sample 6 then gets tw_idx=8.
- Back-to-back frames, LOG_D=1: 64 continuous samples -> no FLUSH between frames, idx wraps 31->0, valid_o continuous after the first 2 cycles.
- Mid-frame reset at sample 10 -> IDLE next cycle; next accepted sample is treated as idx=0 (state=01, valid_o=0).

Source files
------------

// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and sample bus between an SDF stage controller and its neighbours.
// The slave modport is the controller side.
interface sdf_stage_ctrl_if #(
   parameter int unsigned DW    = 17,
   parameter int unsigned N_LOG = 5
);
   logic                   valid_i;
   logic                   ready_o;
   logic signed [DW-1:0]   data_in_r;
   logic signed [DW-1:0]   data_in_i;
   logic signed [DW-1:0]   data_out_r;
   logic signed [DW-1:0]   data_out_i;
   logic [1:0]             state;
   logic                   sr_en;
   logic [N_LOG-2:0]       tw_idx;
   logic                   valid_o;

   modport slave (
      input  valid_i, data_in_r, data_in_i,
      output ready_o, data_out_r, data_out_i, state, sr_en, tw_idx, valid_o
   );

   modport master (
      output valid_i, data_in_r, data_in_i,
      input  ready_o, data_out_r, data_out_i, state, sr_en, tw_idx, valid_o
   );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Control unit for one radix-2 SDF butterfly stage with delay D = 2**LOG_D.
// Outputs are registered together with the accepted sample they describe.
module sdf_stage_ctrl #(
   parameter int unsigned DW    = 17,
   parameter int unsigned N_LOG = 5,
   parameter int unsigned LOG_D = 0
) (
   input logic             clk,
   input logic             rst,
   sdf_stage_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFill  = 2'b01,
      StBfly  = 2'b10,
      StFlush = 2'b11
   } state_e;

   localparam logic [N_LOG-1:0] DCnt     = N_LOG'(2 ** LOG_D);
   localparam logic [N_LOG-1:0] DMask    = N_LOG'(2 ** LOG_D - 1);
   localparam int unsigned      TwShift  = N_LOG - 1 - LOG_D;

   state_e               state_q, state_d;
   logic [N_LOG-1:0]     idx_q, idx_d;
   logic [N_LOG-1:0]     cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic signed [DW-1:0] dr_q, dr_d;
   logic signed [DW-1:0] di_q, di_d;
   logic                 sr_en_q, sr_en_d;
   logic                 valid_q, valid_d;
   logic [N_LOG-2:0]     tw_q, tw_d;
   logic [N_LOG-2:0]     tw_bfly;
   logic                 ready;
   logic                 accept;

   assign ready   = (state_q != StFlush);
   assign accept  = bus.valid_i && ready;
   // Mask keeps the value below 2**(N_LOG-1), so the narrowing cast drops only a zero bit.
   assign tw_bfly = (N_LOG-1)'(idx_q & DMask) << TwShift;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      dr_d    = dr_q;
      di_d    = di_q;
      tw_d    = tw_q;
      sr_en_d = 1'b0;
      valid_d = 1'b0;
      unique case (state_q)
         StIdle, StFill, StBfly: begin
            if (accept) begin
               dr_d    = bus.data_in_r;
               di_d    = bus.data_in_i;
               idx_d   = idx_q + N_LOG'(1);
               sr_en_d = 1'b1;
               if (idx_q[LOG_D]) begin
                  state_d = StBfly;
                  valid_d = 1'b1;
                  tw_d    = tw_bfly;
                  done_d  = 1'b1;
               end else begin
                  state_d = StFill;
                  valid_d = done_q;
                  tw_d    = '0;
               end
            end else if (state_q != StIdle && idx_q == '0) begin
               // Frame boundary with no follow-on sample: drain the delay line.
               state_d = StFlush;
               cnt_d   = N_LOG'(1);
               sr_en_d = 1'b1;
               valid_d = 1'b1;
               tw_d    = '0;
            end
         end
         StFlush: begin
            tw_d = '0;
            if (cnt_q == DCnt) begin
               state_d = StIdle;
               cnt_d   = '0;
               done_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + N_LOG'(1);
               sr_en_d = 1'b1;
               valid_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dr_q    <= '0;
         di_q    <= '0;
         sr_en_q <= 1'b0;
         valid_q <= 1'b0;
         tw_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         dr_q    <= dr_d;
         di_q    <= di_d;
         sr_en_q <= sr_en_d;
         valid_q <= valid_d;
         tw_q    <= tw_d;
      end
   end

   assign bus.ready_o    = ready;
   assign bus.data_out_r = dr_q;
   assign bus.data_out_i = di_q;
   assign bus.state      = state_q;
   assign bus.sr_en      = sr_en_q;
   assign bus.tw_idx     = tw_q;
   assign bus.valid_o    = valid_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Randomized bench: three stage controllers (LOG_D = 0, 1, 2) share one stimulus stream
// and are compared every cycle against a sample-count based reference model.
module tb_sdf_stage_ctrl;
   localparam int unsigned DW    = 17;
   localparam int unsigned N_LOG = 5;
   localparam int          N     = 1 << N_LOG;
   localparam int          NDUT  = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            valid = 1'b1;
   logic [DW-1:0]   din_r = '0;
   logic [DW-1:0]   din_i = '0;

   logic [NDUT-1:0]              got_rdy, got_sr, got_vo;
   logic [NDUT-1:0][DW-1:0]      got_dr, got_di;
   logic [NDUT-1:0][1:0]         got_st;
   logic [NDUT-1:0][N_LOG-2:0]   got_tw;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sdf_stage_ctrl_if #(.DW(DW), .N_LOG(N_LOG)) bus ();
      assign bus.valid_i   = valid;
      assign bus.data_in_r = din_r;
      assign bus.data_in_i = din_i;
      sdf_stage_ctrl #(.DW(DW), .N_LOG(N_LOG), .LOG_D(g)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign got_rdy[g] = bus.ready_o;
      assign got_dr[g]  = bus.data_out_r;
      assign got_di[g]  = bus.data_out_i;
      assign got_st[g]  = bus.state;
      assign got_sr[g]  = bus.sr_en;
      assign got_tw[g]  = bus.tw_idx;
      assign got_vo[g]  = bus.valid_o;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: k = samples accepted in this burst, fl = flush cycles left.
   int            k_m  [NDUT];
   int            fl_m [NDUT];
   bit            busy_m [NDUT];
   logic [DW-1:0] e_dr [NDUT];
   logic [DW-1:0] e_di [NDUT];
   int            e_st [NDUT];
   int            e_sr [NDUT];
   int            e_vo [NDUT];
   int            e_tw [NDUT];

   task automatic check_eq(input string tag, input int u, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s[ld=%0d] got=%0d exp=%0d @%0t", tag, u, got, exp, $time);
   endtask

   task automatic model_step(input int u, input bit r, input bit v);
      int d;
      int j;
      int ph;
      d = 1 << u;
      if (r) begin
         k_m[u] = 0; fl_m[u] = 0; busy_m[u] = 0;
         e_dr[u] = '0; e_di[u] = '0;
         e_st[u] = 0; e_sr[u] = 0; e_vo[u] = 0; e_tw[u] = 0;
      end else if (fl_m[u] > 0) begin
         fl_m[u]--;
         e_tw[u] = 0;
         if (fl_m[u] == 0) begin
            e_st[u] = 0; e_sr[u] = 0; e_vo[u] = 0;
            busy_m[u] = 0; k_m[u] = 0;
         end else begin
            e_st[u] = 3; e_sr[u] = 1; e_vo[u] = 1;
         end
      end else if (v) begin
         j  = k_m[u] % N;
         ph = (j / d) % 2;
         e_dr[u] = din_r; e_di[u] = din_i;
         e_st[u] = ph ? 2 : 1;
         e_sr[u] = 1;
         e_vo[u] = (ph == 1 || k_m[u] >= 2 * d) ? 1 : 0;
         e_tw[u] = ph ? (j % d) * (N / (2 * d)) : 0;
         k_m[u]++;
         busy_m[u] = 1;
      end else if (busy_m[u] && (k_m[u] % N) == 0) begin
         fl_m[u] = d;
         e_st[u] = 3; e_sr[u] = 1; e_vo[u] = 1; e_tw[u] = 0;
      end else begin
         e_sr[u] = 0; e_vo[u] = 0;
      end
   endtask

   // Called at a falling edge: drive, check ready, advance model, check registered outputs.
   task automatic cycle(input bit r, input bit v);
      rst   = r;
      valid = v;
      din_r = DW'($urandom);
      din_i = DW'($urandom);
      #1;
      for (int u = 0; u < NDUT; u++) begin
         check_eq("ready_o", u, longint'(got_rdy[u]), longint'(fl_m[u] == 0));
         model_step(u, r, v);
      end
      @(posedge clk);
      #1;
      for (int u = 0; u < NDUT; u++) begin
         check_eq("data_out_r", u, longint'(got_dr[u]), longint'(e_dr[u]));
         check_eq("data_out_i", u, longint'(got_di[u]), longint'(e_di[u]));
         check_eq("state", u, longint'(got_st[u]), longint'(e_st[u]));
         check_eq("sr_en", u, longint'(got_sr[u]), longint'(e_sr[u]));
         check_eq("tw_idx", u, longint'(got_tw[u]), longint'(e_tw[u]));
         check_eq("valid_o", u, longint'(got_vo[u]), longint'(e_vo[u]));
      end
      @(negedge clk);
   endtask

   initial begin
      int p;
      for (int u = 0; u < NDUT; u++) model_step(u, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      // Reset held with valid high: sample must be dropped.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      // Two back-to-back frames, then end of burst and flush.
      for (int i = 0; i < 2 * N; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
      // One frame with a 3-cycle stall after sample 5.
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      for (int i = 0; i < N - 6; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
      // Mid-frame reset at sample 10, then a fresh burst.
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
      // Random segments with varying valid density and rare resets.
      for (int s = 0; s < 20; s++) begin
         p = (s % 3 == 0) ? 100 : ((s % 3 == 1) ? 95 : 70);
         for (int i = 0; i < 80; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < p);
         for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
